// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with a two-entry (main + skid) output buffer
module id_stage #(
    parameter int RV32E  = 0,
    parameter int M_EN   = 0,
    parameter int CSR_EN = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_inst_addr,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_inst_addr,
    output logic [4:0]  o_rs1_addr,
    output logic [4:0]  o_rs2_addr_shamt,
    output logic [4:0]  o_rd_addr,
    output logic        o_rd_we,
    output logic [31:0] o_imm,
    output logic [11:0] o_csr_addr,
    output logic [3:0]  o_class,
    output logic        o_illegal
);
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] imm;
        logic [11:0] csr;
        logic [3:0]  cls;
        logic        ill;
    } entry_t;

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        use_rd, use_rs1, use_rs2, use_sh, bad;
    logic        main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, in_xfer, out_xfer;
    entry_t      dec, main_q, main_d, skid_q, skid_d;

    assign opc   = i_inst[6:0];
    assign f3    = i_inst[14:12];
    assign f7    = i_inst[31:25];
    assign imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
    assign imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign imm_b = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign imm_u = {i_inst[31:12], 12'b0};
    assign imm_j = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    // Decode the incoming word; illegal words collapse to class 15 with only the PC kept
    always_comb begin
        dec     = '0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_sh  = 1'b0;
        bad     = 1'b0;
        case (opc)
            7'b0110011: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec.cls = (f7 == 7'b0000001) ? 4'd13 : 4'd0;
                bad     = (f7 == 7'b0000001) ? (M_EN == 0)
                        : !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            7'b0010011: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_sh  = (f3[1:0] == 2'b01);
                dec.cls = 4'd1;
                dec.imm = imm_i;
                bad     = (f3 == 3'b001) ? (f7 != 7'b0)
                        : (f3 == 3'b101) ? (f7 != 7'b0 && f7 != 7'b0100000) : 1'b0;
            end
            7'b0000011: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                dec.cls = 4'd2;
                dec.imm = imm_i;
                bad     = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            7'b0100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec.cls = 4'd3;
                dec.imm = imm_s;
                bad     = f3[2] || (f3 == 3'b011);
            end
            7'b1100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec.cls = 4'd4;
                dec.imm = imm_b;
                bad     = (f3[2:1] == 2'b01);
            end
            7'b0110111: begin
                use_rd  = 1'b1;
                dec.cls = 4'd5;
                dec.imm = imm_u;
            end
            7'b0010111: begin
                use_rd  = 1'b1;
                dec.cls = 4'd6;
                dec.imm = imm_u;
            end
            7'b1101111: begin
                use_rd  = 1'b1;
                dec.cls = 4'd7;
                dec.imm = imm_j;
            end
            7'b1100111: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                dec.cls = 4'd8;
                dec.imm = imm_i;
                bad     = (f3 != 3'b000);
            end
            7'b0001111: begin
                dec.cls = 4'd9;
                bad     = (f3 != 3'b000);
            end
            7'b1110011: begin
                if (f3 == 3'b000) begin
                    dec.cls = i_inst[20] ? 4'd11 : 4'd10;
                    bad     = (i_inst != 32'h00000073) && (i_inst != 32'h00100073);
                end else begin
                    use_rd  = 1'b1;
                    use_rs1 = !f3[2];
                    dec.cls = 4'd12;
                    dec.csr = i_inst[31:20];
                    dec.imm = f3[2] ? {27'b0, i_inst[19:15]} : 32'b0;
                    bad     = (f3 == 3'b100) || (CSR_EN == 0);
                end
            end
            default: bad = 1'b1;
        endcase
        dec.pc  = i_inst_addr;
        dec.rd  = use_rd ? i_inst[11:7] : 5'd0;
        dec.rs1 = use_rs1 ? i_inst[19:15] : 5'd0;
        dec.rs2 = (use_rs2 || use_sh) ? i_inst[24:20] : 5'd0;
        dec.we  = use_rd && (i_inst[11:7] != 5'd0);
        if (RV32E != 0 && ((use_rd && i_inst[11]) || (use_rs1 && i_inst[19]) || (use_rs2 && i_inst[24])))
            bad = 1'b1;
        if (bad) begin
            dec     = '0;
            dec.pc  = i_inst_addr;
            dec.cls = 4'd15;
            dec.ill = 1'b1;
        end
    end

    assign in_xfer  = i_valid && !skid_vld_q;
    assign out_xfer = main_vld_q && i_ready;

    // Buffer next state: main refills from skid first so program order is kept
    always_comb begin
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        main_d     = main_q;
        skid_d     = skid_q;
        if (out_xfer) begin
            main_vld_d = skid_vld_q || in_xfer;
            main_d     = skid_vld_q ? skid_q : dec;
            skid_vld_d = 1'b0;
        end else if (in_xfer) begin
            main_vld_d = 1'b1;
            skid_vld_d = main_vld_q;
            main_d     = main_vld_q ? main_q : dec;
            skid_d     = main_vld_q ? dec : skid_q;
        end
    end

    // Buffer registers; reset and flush both empty the buffer
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    assign o_ready          = !skid_vld_q;
    assign o_valid          = main_vld_q;
    assign o_inst_addr      = main_q.pc;
    assign o_rs1_addr       = main_q.rs1;
    assign o_rs2_addr_shamt = main_q.rs2;
    assign o_rd_addr        = main_q.rd;
    assign o_rd_we          = main_q.we;
    assign o_imm            = main_q.imm;
    assign o_csr_addr       = main_q.csr;
    assign o_class          = main_q.cls;
    assign o_illegal        = main_q.ill;
endmodule
